// File: rtl/u_rec_fifo_pkg.sv
// Shared constants for the UART receive path and its receive FIFO.
package u_rec_fifo_pkg;

  // Receiver constants
  localparam int REC_DATA_W    = 8;

  // Receive FIFO defaults
  localparam int FIFO_DEPTH    = 8;
  localparam int FIFO_ADDR_W   = 3;
  localparam int MIN_FRAME_LOW = 64;

  // Width of the low-period counter that qualifies a frame
  localparam int LOW_CNT_W     = 8;

  // Saturating increment so very long idle-low periods never wrap back below the threshold
  function automatic logic [LOW_CNT_W-1:0] sat_inc(input logic [LOW_CNT_W-1:0] v);
    logic [LOW_CNT_W-1:0] r;
    if (v == {LOW_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + LOW_CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/u_fifo_mem.sv
// Storage for the receive FIFO: synchronous write, asynchronous read, no reset on contents.
module u_fifo_mem
  import u_rec_fifo_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int W      = REC_DATA_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [W-1:0]      wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [W-1:0]      rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Write port: capture the byte on the clock edge when enabled
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/u_rec_fifo.sv
// Receive-side buffer behind the UART receiver: qualifies completed frames from the
// ready level, pushes bytes into a fall-through FIFO and flags overruns.
module u_rec_fifo
  import u_rec_fifo_pkg::*;
#(
  parameter int DEPTH   = FIFO_DEPTH,
  parameter int ADDR_W  = FIFO_ADDR_W,
  parameter int MIN_LOW = MIN_FRAME_LOW
) (
  input  logic              sys_clk,
  input  logic              sys_rst_l,
  input  logic [7:0]        rec_dataH,
  input  logic              rec_readyH,
  input  logic              fifo_readH,
  input  logic              clr_ovrH,
  output logic [7:0]        fifo_dataH,
  output logic              fifo_validH,
  output logic              fifo_fullH,
  output logic [ADDR_W:0]   fifo_countH,
  output logic              overrunH
);

  logic                 ready_q,   ready_d;
  logic                 armed_q,   armed_d;
  logic [LOW_CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic [ADDR_W-1:0]    wr_ptr_q,  wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q,  rd_ptr_d;
  logic [ADDR_W:0]      count_q,   count_d;
  logic                 ovr_q,     ovr_d;

  logic                 rise_s, fall_s, push_s, pop_s, full_s, wr_en_s;
  logic [7:0]           rdata_s;

  assign full_s = (count_q == (ADDR_W+1)'(DEPTH));

  // Next-state logic: edge detect, frame qualification, pointer/count/overrun update
  always_comb begin
    ready_d   = rec_readyH;
    armed_d   = armed_q;
    low_cnt_d = low_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovr_d     = ovr_q;

    rise_s = rec_readyH & ~ready_q;
    fall_s = ~rec_readyH & ready_q;

    // A frame only counts if a fall was seen since the last rise and the line stayed low long enough
    if (fall_s) begin
      armed_d = 1'b1;
    end else if (rise_s) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end

    if (fall_s) begin
      low_cnt_d = LOW_CNT_W'(0);
    end else if (!rec_readyH) begin
      low_cnt_d = sat_inc(low_cnt_q);
    end else begin
      low_cnt_d = low_cnt_q;
    end

    push_s  = rise_s & armed_q & (low_cnt_q >= LOW_CNT_W'(MIN_LOW - 1));
    pop_s   = fifo_readH & (count_q != (ADDR_W+1)'(0));
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
    wr_en_s = push_s & (~full_s | pop_s);

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    // Setting wins over a coincident clear
    if (push_s & full_s & ~pop_s) begin
      ovr_d = 1'b1;
    end else if (clr_ovrH) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      ready_q   <= 1'b0;
      armed_q   <= 1'b0;
      low_cnt_q <= LOW_CNT_W'(0);
      wr_ptr_q  <= ADDR_W'(0);
      rd_ptr_q  <= ADDR_W'(0);
      count_q   <= (ADDR_W+1)'(0);
      ovr_q     <= 1'b0;
    end else begin
      ready_q   <= ready_d;
      armed_q   <= armed_d;
      low_cnt_q <= low_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
    end
  end

  u_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (8)
  ) u_mem (
    .clk_i   (sys_clk),
    .we_i    (wr_en_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (rec_dataH),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_s)
  );

  // Head byte is forced to zero while empty so stale storage never shows at the output
  assign fifo_validH = (count_q != (ADDR_W+1)'(0));
  assign fifo_fullH  = full_s;
  assign fifo_countH = count_q;
  assign overrunH    = ovr_q;
  assign fifo_dataH  = fifo_validH ? rdata_s : 8'h00;

endmodule

// File: tb/tb_u_rec_fifo.sv
// Self-checking bench for u_rec_fifo against a queue-based reference model.
module tb_u_rec_fifo;

  localparam int DEPTH   = 8;
  localparam int MIN_LOW = 64;

  logic       sys_clk = 1'b0;
  logic       sys_rst_l;
  logic [7:0] rec_dataH;
  logic       rec_readyH;
  logic       fifo_readH;
  logic       clr_ovrH;
  logic [7:0] fifo_dataH;
  logic       fifo_validH;
  logic       fifo_fullH;
  logic [3:0] fifo_countH;
  logic       overrunH;

  u_rec_fifo dut (
    .sys_clk     (sys_clk),
    .sys_rst_l   (sys_rst_l),
    .rec_dataH   (rec_dataH),
    .rec_readyH  (rec_readyH),
    .fifo_readH  (fifo_readH),
    .clr_ovrH    (clr_ovrH),
    .fifo_dataH  (fifo_dataH),
    .fifo_validH (fifo_validH),
    .fifo_fullH  (fifo_fullH),
    .fifo_countH (fifo_countH),
    .overrunH    (overrunH)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the FIFO is a byte queue; a frame is qualified by the length of the
  // low period seen since the last falling edge of the ready level.
  logic [7:0] q_m [$];
  int  prev_m      = 0;
  int  seen_fall_m = 0;
  int  low_len_m   = 0;
  int  ovr_m       = 0;
  bit  rnd_mode    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int rise, fall, push, pop, full_before, set_ovr;
    if (!sys_rst_l) begin
      q_m.delete();
      prev_m = 0; seen_fall_m = 0; low_len_m = 0; ovr_m = 0;
      return;
    end
    rise = (rec_readyH && !prev_m) ? 1 : 0;
    fall = (!rec_readyH && prev_m) ? 1 : 0;
    push = 0;
    if (rise) begin
      push = (seen_fall_m && low_len_m >= MIN_LOW) ? 1 : 0;
      seen_fall_m = 0;
    end else if (fall) begin
      seen_fall_m = 1;
      low_len_m = 1;
    end else if (!rec_readyH) begin
      low_len_m++;
    end
    full_before = (q_m.size() == DEPTH) ? 1 : 0;
    pop = (fifo_readH && q_m.size() > 0) ? 1 : 0;
    set_ovr = 0;
    if (pop) void'(q_m.pop_front());
    if (push) begin
      if (!full_before || pop) q_m.push_back(rec_dataH);
      else set_ovr = 1;
    end
    if (set_ovr) ovr_m = 1;
    else if (clr_ovrH) ovr_m = 0;
    prev_m = rec_readyH ? 1 : 0;
  endtask

  task automatic check_outputs();
    chk("valid", 32'(fifo_validH), 32'(q_m.size() != 0));
    chk("full",  32'(fifo_fullH),  32'(q_m.size() == DEPTH));
    chk("count", 32'(fifo_countH), 32'(q_m.size()));
    chk("ovr",   32'(overrunH),    32'(ovr_m));
    chk("data",  32'(fifo_dataH),  (q_m.size() != 0) ? 32'(q_m[0]) : 32'h0);
  endtask

  task automatic tick();
    if (rnd_mode) begin
      fifo_readH = ($urandom_range(0, 3) == 0);
      clr_ovrH   = ($urandom_range(0, 15) == 0);
    end
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    check_outputs();
  endtask

  task automatic send_frame(input int low_len, input logic [7:0] b, input bit rd_on_rise);
    rec_readyH = 1'b0;
    for (int i = 0; i < low_len; i++) begin
      rec_dataH = 8'($urandom);
      tick();
    end
    rec_readyH = 1'b1;
    rec_dataH  = b;
    if (rd_on_rise) fifo_readH = 1'b1;
    tick();
    if (!rnd_mode) fifo_readH = 1'b0;
    tick();
    tick();
  endtask

  task automatic read_one();
    fifo_readH = 1'b1;
    tick();
    fifo_readH = 1'b0;
  endtask

  initial begin
    int lens [7] = '{5, 6, 63, 64, 65, 100, 20};
    sys_rst_l  = 1'b0;
    rec_readyH = 1'b0;
    rec_dataH  = 8'h00;
    fifo_readH = 1'b0;
    clr_ovrH   = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(fifo_validH), 32'h0);
    chk("rst_count", 32'(fifo_countH), 32'h0);

    // 1: first rise after reset is never pushed
    sys_rst_l = 1'b1;
    tick();
    rec_readyH = 1'b1;
    repeat (4) tick();
    chk("t1_valid", 32'(fifo_validH), 32'h0);
    chk("t1_count", 32'(fifo_countH), 32'h0);

    // 2: long frame pushes, then a read empties
    send_frame(150, 8'hA5, 1'b0);
    chk("t2_data",  32'(fifo_dataH),  32'hA5);
    chk("t2_count", 32'(fifo_countH), 32'h1);
    read_one();
    chk("t2_empty", 32'(fifo_validH), 32'h0);

    // 3: false start ignored, real frame accepted; threshold boundary 63/64
    send_frame(5, 8'h11, 1'b0);
    chk("t3_false", 32'(fifo_countH), 32'h0);
    send_frame(150, 8'h3C, 1'b0);
    chk("t3_data", 32'(fifo_dataH), 32'h3C);
    read_one();
    send_frame(MIN_LOW - 1, 8'h22, 1'b0);
    chk("t3_short", 32'(fifo_countH), 32'h0);
    send_frame(MIN_LOW, 8'h33, 1'b0);
    chk("t3_min", 32'(fifo_dataH), 32'h33);
    read_one();

    // 4: overflow with nine frames, ordered drain, clear overrun
    for (int i = 1; i <= 9; i++) send_frame(70, 8'(i), 1'b0);
    chk("t4_full", 32'(fifo_fullH), 32'h1);
    chk("t4_cnt",  32'(fifo_countH), 32'h8);
    chk("t4_ovr",  32'(overrunH), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      chk("t4_head", 32'(fifo_dataH), 32'(i));
      read_one();
    end
    clr_ovrH = 1'b1;
    tick();
    clr_ovrH = 1'b0;
    chk("t4_clr", 32'(overrunH), 32'h0);

    // 5: push into full FIFO coincident with a pop
    for (int i = 0; i < 8; i++) send_frame(70, 8'h40 + 8'(i), 1'b0);
    send_frame(70, 8'h77, 1'b1);
    chk("t5_cnt",  32'(fifo_countH), 32'h8);
    chk("t5_ovr",  32'(overrunH), 32'h0);
    chk("t5_head", 32'(fifo_dataH), 32'h41);
    repeat (8) read_one();
    chk("t5_drain", 32'(fifo_validH), 32'h0);

    // 6: reset mid-frame discards contents and the frame in progress
    for (int i = 0; i < 3; i++) send_frame(80, 8'hB0 + 8'(i), 1'b0);
    rec_readyH = 1'b0;
    repeat (20) tick();
    sys_rst_l = 1'b0;
    tick();
    sys_rst_l = 1'b1;
    chk("t6_cnt", 32'(fifo_countH), 32'h0);
    repeat (150) tick();
    rec_readyH = 1'b1;
    rec_dataH  = 8'hEE;
    repeat (3) tick();
    chk("t6_nopush", 32'(fifo_validH), 32'h0);

    // Randomized frames, reads and clears against the model
    rnd_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      send_frame(lens[$urandom_range(0, 6)], 8'($urandom), 1'b0);
    end
    rnd_mode   = 1'b0;
    clr_ovrH   = 1'b0;
    fifo_readH = 1'b1;
    repeat (10) tick();
    fifo_readH = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/u_rec_fifo.md
Name: u_rec_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver.
- Qualifies each completed frame from the receiver's `rec_readyH` / `rec_dataH` pair and pushes the byte into a small first-word-fall-through FIFO.
- Presents a valid/read interface to the host logic.
- Rejects the spurious ready edges produced at reset and after false start bits, and flags overruns.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.
- ADDR_W, 3, log2(DEPTH).
- MIN_LOW, 64, minimum consecutive cycles `rec_readyH` must be low for the following rising edge to count as a real frame.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_l  in  1  synchronous active-low reset.
- rec_dataH  in  8  received byte from the receiver; stable while `rec_readyH` is high.
- rec_readyH  in  1  receiver idle/done level; low during a frame, rises when the frame completes.
- fifo_readH  in  1  host pop request.
- clr_ovrH  in  1  clears `overrunH`.
- fifo_dataH  out  8  head-of-FIFO byte; valid when `fifo_validH` is high.
- fifo_validH  out  1  FIFO not empty.
- fifo_fullH  out  1  FIFO holds DEPTH entries.
- fifo_countH  out  ADDR_W+1  current entry count, 0..DEPTH.
- overrunH  out  1  sticky: a qualified byte was dropped because the FIFO was full.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: all state updates only on the `sys_clk` rising edge while `sys_rst_l`=0.
- Reset values:
  - `ready_d`=0, `armed`=0, `low_cnt`=0, `wr_ptr`=`rd_ptr`=0, `count`=0.
  - `fifo_validH`=0, `fifo_fullH`=0, `fifo_countH`=0, `overrunH`=0, `fifo_dataH`=0.
- Edge detection: `ready_d` registers `rec_readyH` every cycle.
  - rise = `rec_readyH` & ~`ready_d`.
  - fall = ~`rec_readyH` & `ready_d`.
- Low-period counter `low_cnt` (8 bit, saturating at 255):
  - Cleared on fall.
  - Incremented while `rec_readyH`=0.
  - Held while high.
- `armed`:
  - Set on fall.
  - Cleared on any rise.
  - Purpose: the first rise after reset (receiver idle with `rec_dataH`=0) is never pushed.
- push = rise & `armed` & (`low_cnt` >= MIN_LOW-1).
  - A rise after a short low pulse (false start bit, 5-6 cycles) is discarded with no FIFO change.
- pop = `fifo_readH` & `fifo_validH`. A read while empty is ignored.
- FIFO update rules:
  - push & ~full: write `rec_dataH` at `wr_ptr`; `wr_ptr`+1 (wraps mod DEPTH); `count`+1.
  - pop: `rd_ptr`+1 (wraps); `count`-1.
  - push & pop on the same cycle: both occur, `count` unchanged. This holds even when full, because the pop frees the slot and the write is accepted.
  - push & full & ~pop: byte dropped, pointers and `count` unchanged, `overrunH` set.
- `overrunH`:
  - Cleared by `clr_ovrH`.
  - If set and clear coincide, set wins.
- Outputs:
  - `fifo_dataH` = mem[`rd_ptr`], combinational (fall-through).
  - `fifo_validH` = (`count`!=0).
  - `fifo_fullH` = (`count`==DEPTH).
  - `fifo_countH` = `count`.
- Latency: a push decided at clock edge N makes the byte visible on `fifo_dataH` with `fifo_validH`=1 immediately after edge N (one cycle after `rec_readyH` first rises).
- Reset mid-frame: `armed` is cleared, so the in-progress frame's completion edge is ignored. FIFO contents are discarded (pointers reset; memory need not be cleared).

Decomposition:
- Shared include, alongside the receiver constants: FIFO_DEPTH, FIFO_ADDR_W, MIN_FRAME_LOW defaults.
- One sub-module, u_fifo_mem:
  - DEPTH x 8 register array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr -> rdata).
  - No reset on storage.
- Pointer, count, edge-detect and qualification logic stay in u_rec_fifo.

Test Plan:
1. Reset release with `rec_readyH` going 0 -> 1 one cycle later, `rec_dataH`=8'h00 -> `fifo_validH` stays 0 and `fifo_countH`=0.
2. `rec_readyH` low for 150 cycles, then high with `rec_dataH`=8'hA5 -> on the next cycle `fifo_validH`=1, `fifo_dataH`=8'hA5, `fifo_countH`=1; pulse `fifo_readH` -> `fifo_validH`=0.
3. `rec_readyH` low for 5 cycles (false start), then high -> no push and `count` unchanged; a following 150-cycle frame with 8'h3C is pushed normally.
4. Nine valid frames 8'h01..8'h09 with no reads -> `fifo_fullH`=1, `count`=8, `overrunH`=1; reads return 8'h01..8'h08 in order; `clr_ovrH` clears `overrunH`.
5. FIFO full and a frame completes (8'h77) on the same cycle as `fifo_readH` -> head pops, 8'h77 is accepted, `count` stays 8, `overrunH` stays 0.
6. `sys_rst_l` asserted for 1 cycle while `rec_readyH` is low mid-frame with 3 entries queued -> `count`=0 after reset; that frame's completion edge is not pushed.
